// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: operand-mux select codes and the zero register.
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // ID/EX register value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back data
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_select.sv
// Operand-mux select for one EX source index; the EX/MEM match wins over MEM/WB.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] src_idx,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_we,
  output logic [1:0]       sel
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

  always_comb begin
    sel = FWD_REG;
    if (mem_we && (mem_rd != ZERO_IDX) && (mem_rd == src_idx)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != ZERO_IDX) && (wb_rd == src_idx)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_W = 5
`ifdef FWD_STATS_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_use_rt_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] fwd_cnt_o
`endif
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             mr;
  } ex_entry_t;

  // Downstream stages only need the destination for forwarding decisions
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
  } wr_entry_t;

  ex_entry_t ex_q;
  wr_entry_t mem_q;
  wr_entry_t wb_q;

  // Tracking pipeline; a stall or flush inserts a bubble into EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= '{rd: ex_q.rd, we: ex_q.we};
      wb_q  <= mem_q;
      if (flush_i || stall_o) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                  we: id_regwrite_i, mr: id_memread_i};
      end
    end
  end

  fwd_select #(.REG_W(REG_W)) u_sel_a (
    .src_idx (ex_q.rs),
    .mem_rd  (mem_q.rd),
    .mem_we  (mem_q.we),
    .wb_rd   (wb_q.rd),
    .wb_we   (wb_q.we),
    .sel     (fwd_a_o)
  );

  fwd_select #(.REG_W(REG_W)) u_sel_b (
    .src_idx (ex_q.rt),
    .mem_rd  (mem_q.rd),
    .mem_we  (mem_q.we),
    .wb_rd   (wb_q.rd),
    .wb_we   (wb_q.we),
    .sel     (fwd_b_o)
  );

  // Load in EX whose destination the ID instruction reads
  always_comb begin
    stall_o = 1'b0;
    if (ex_q.mr && (ex_q.rd != ZERO_IDX)) begin
      stall_o = (ex_q.rd == id_rs_i) || (id_use_rt_i && (ex_q.rd == id_rt_i));
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if ((fwd_a_o != FWD_REG) || (fwd_b_o != FWD_REG)) begin
        fwd_cnt_o <= fwd_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule
